// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared constants, opcodes and fetch FSM encoding
// Rev 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with load, hold and bubble controls
// Rev 1.0 - initial release
// ============================================================================
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [31:0]        pcplus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pcplus4,
  output logic               valid
);

  // Bubble outranks load; PC+4 is left untouched by a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr   <= NOP_INSTR;
      pcplus4 <= 32'h0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pcplus4 <= pcplus4_in;
      valid   <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : MIPS IF stage - PC, next-PC select, imem handshake, IF/ID reg
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
// Rev 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrc,
  input  logic               IsJ,
  input  logic               IF_FLUSH,
  input  logic [31:0]        BranchTarget,
  input  logic [31:0]        JumpTarget,
  input  logic               Stall,
  output logic               ImemReq,
  output logic [31:0]        ImemAddr,
  input  logic               ImemReady,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [31:0]        IF_ID_PCPlus4,
  output logic               IF_ID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        RedirectCount,
  output logic [31:0]        StallCycleCount
`endif
);

  if (MAX_OUTSTANDING != 1) begin : g_bad_outstanding
    $error("fetch_stage supports exactly one outstanding request");
  end

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;
  logic [INSTR_W-1:0] skid_data;
  logic [INSTR_W-1:0] ifid_instr_in;
  logic               req;
  logic               redirect;
  logic               pc_advance;
  logic               ifid_load;
  logic               ifid_bubble;

  assign redirect = IsJ | PCSrc;
  assign pc_plus4 = pc + 32'd4;
  assign next_pc  = IsJ   ? align_word(JumpTarget)   :
                    PCSrc ? align_word(BranchTarget) : pc_plus4;

  assign ImemReq  = req;
  assign ImemAddr = pc;

  // With no returned word, IF/ID takes a bubble so nothing stale is re-issued.
  always_comb begin
    pc_advance    = 1'b0;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = ImemData;
    if (!Stall) begin
      case (state)
        REQ: begin
          pc_advance = ImemReady | redirect;
          if (IF_FLUSH || !ImemReady) ifid_bubble = 1'b1;
          else                        ifid_load   = 1'b1;
        end
        HOLD: begin
          pc_advance    = 1'b1;
          ifid_instr_in = skid_data;
          if (IF_FLUSH || redirect) ifid_bubble = 1'b1;
          else                      ifid_load   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req       <= 1'b0;
      skid_data <= NOP_INSTR;
    end else begin
      if (pc_advance) pc <= next_pc;
      case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (Stall && ImemReady) begin
            skid_data <= ImemData;
            req       <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!Stall) begin
            skid_data <= NOP_INSTR;
            req       <= 1'b1;
            state     <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (ifid_instr_in),
    .pcplus4_in (pc_plus4),
    .instr      (IF_ID_Instr),
    .pcplus4    (IF_ID_PCPlus4),
    .valid      (IF_ID_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;
  logic        redirect_taken;

  assign redirect_taken = redirect & ~Stall & (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if (redirect_taken && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
      if (Stall && (stall_cnt != 32'hFFFF_FFFF))             stall_cnt    <= stall_cnt + 32'd1;
    end
  end

  assign RedirectCount   = redirect_cnt;
  assign StallCycleCount = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_stage : randomized and directed checks of fetch_stage vs a model
// Rev 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc = 1'b0, IsJ = 1'b0, IF_FLUSH = 1'b0, Stall = 1'b0, ImemReady = 1'b0;
  logic [31:0] BranchTarget = 32'h0, JumpTarget = 32'h0, ImemData = 32'h0;
  wire         ImemReq;
  wire  [31:0] ImemAddr;
  wire  [31:0] IF_ID_Instr;
  wire  [31:0] IF_ID_PCPlus4;
  wire         IF_ID_Valid;

  int checks = 0;
  int errors = 0;

  // Reference model: PC, IF/ID contents and a queue for a word held during a stall.
  bit          m_idle;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  logic [31:0] m_skid[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .MAX_OUTSTANDING(1)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .IsJ(IsJ), .IF_FLUSH(IF_FLUSH),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemData(ImemData),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_skid.delete();
  endtask

  task automatic model_step();
    logic [31:0] seq, tgt;
    bit redir;
    if (!rst) begin model_reset(); return; end
    seq   = m_pc + 32'd4;
    redir = IsJ | PCSrc;
    tgt   = IsJ ? JumpTarget : BranchTarget;
    tgt[1:0] = 2'b00;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_skid.size() == 0) begin
      if (!Stall) begin
        if (ImemReady && !IF_FLUSH) begin m_instr = ImemData; m_pc4 = seq; m_valid = 1'b1; end
        else begin m_instr = 32'h0; m_valid = 1'b0; end
        if (ImemReady || redir) m_pc = redir ? tgt : seq;
      end else if (ImemReady) begin
        m_skid.push_back(ImemData);
      end
    end else if (!Stall) begin
      if (IF_FLUSH || redir) begin m_instr = 32'h0; m_valid = 1'b0; end
      else begin m_instr = m_skid[0]; m_pc4 = seq; m_valid = 1'b1; end
      m_pc = redir ? tgt : seq;
      m_skid.delete();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit rdy, input bit br, input bit j, input bit fl,
                       input logic [31:0] bt, input logic [31:0] jt);
    Stall = st; ImemReady = rdy; PCSrc = br; IsJ = j; IF_FLUSH = fl;
    BranchTarget = bt; JumpTarget = jt;
    ImemData = rdy ? memword(m_pc) : 32'hBAD0_BAD0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_req_addr: got req=%b addr=%h, expected req=0 addr=0", ImemReq, ImemAddr);
    end
    checks++;
    if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL reset_ifid: got v=%b instr=%h pc4=%h, expected all zero", IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    checks++;
    if (ImemReq !== 1'b0) begin
      errors++; $display("FAIL idle_req: got %b expected 0", ImemReq);
    end
    tick();
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h, expected req=1 addr=0", ImemReq, ImemAddr);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checks++;
      if ({ImemAddr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instr} !==
          {32'(4*(k+1)), 32'(4*(k+1)), 1'b1, memword(32'(4*k))}) begin
        errors++; $display("FAIL seq_fetch k=%0d: got addr=%h pc4=%h v=%b instr=%h, expected addr=%h pc4=%h v=1 instr=%h",
                           k, ImemAddr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instr, 32'(4*(k+1)), 32'(4*(k+1)), memword(32'(4*k)));
      end
      checks++;
      if ({ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !==
          {(!m_idle && m_skid.size() == 0), m_pc, m_valid, m_instr, m_pc4}) begin
        errors++; $display("FAIL seq_model k=%0d: got req=%b addr=%h v=%b instr=%h pc4=%h, expected addr=%h v=%b instr=%h pc4=%h",
                           k, ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, m_pc, m_valid, m_instr, m_pc4);
      end
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    tick();
    checks++;
    if ({ImemAddr, IF_ID_Valid, IF_ID_Instr} !== {32'h40, 1'b0, 32'h0}) begin
      errors++; $display("FAIL branch_redirect: got addr=%h v=%b instr=%h, expected addr=40 v=0 instr=0", ImemAddr, IF_ID_Valid, IF_ID_Instr);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, ImemAddr} !== {1'b1, memword(32'h40), 32'h44, 32'h44}) begin
      errors++; $display("FAIL branch_target_fetch: got v=%b instr=%h pc4=%h addr=%h, expected v=1 instr=%h pc4=44 addr=44",
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, ImemAddr, memword(32'h40));
    end
  endtask

  task automatic test_jump_priority();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h100);
    tick();
    checks++;
    if (ImemAddr !== 32'h100) begin
      errors++; $display("FAIL jump_priority: got addr=%h expected 00000100", ImemAddr);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({IF_ID_Instr, IF_ID_PCPlus4} !== {memword(32'h100), 32'h104}) begin
      errors++; $display("FAIL jump_fetch: got instr=%h pc4=%h expected instr=%h pc4=104", IF_ID_Instr, IF_ID_PCPlus4, memword(32'h100));
    end
  endtask

  task automatic test_stall_skid();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ImemData = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !==
          {1'b0, 32'h104, 1'b1, memword(32'h100), 32'h104}) begin
        errors++; $display("FAIL stall_freeze c=%0d: got req=%b addr=%h v=%b instr=%h pc4=%h, expected req=0 addr=104 v=1 instr=%h pc4=104",
                           c, ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, memword(32'h100));
      end
      // Redirect and flush presented under stall must be ignored.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b1, 32'h108, 1'b1, 32'hDEAD_BEEF, 32'h108}) begin
      errors++; $display("FAIL stall_release: got req=%b addr=%h v=%b instr=%h pc4=%h, expected req=1 addr=108 v=1 instr=deadbeef pc4=108",
                         ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({IF_ID_Instr, ImemAddr} !== {memword(32'h108), 32'h10C}) begin
      errors++; $display("FAIL stall_resume: got instr=%h addr=%h expected instr=%h addr=10c", IF_ID_Instr, ImemAddr, memword(32'h108));
    end
  endtask

  task automatic test_not_ready_redirect();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({ImemReq, ImemAddr, IF_ID_Valid} !== {1'b1, 32'h10C, 1'b0}) begin
      errors++; $display("FAIL not_ready_wait: got req=%b addr=%h v=%b expected req=1 addr=10c v=0", ImemReq, ImemAddr, IF_ID_Valid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    tick();
    checks++;
    if ({ImemReq, ImemAddr, IF_ID_Valid} !== {1'b1, 32'h200, 1'b0}) begin
      errors++; $display("FAIL not_ready_redirect: got req=%b addr=%h v=%b expected req=1 addr=200 v=0", ImemReq, ImemAddr, IF_ID_Valid);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b1, memword(32'h200), 32'h204}) begin
      errors++; $display("FAIL not_ready_fetch: got v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=204",
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, memword(32'h200));
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFE);
    tick();
    checks++;
    if (ImemAddr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_jump_align: got addr=%h expected fffffffc", ImemAddr);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({ImemAddr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instr} !== {32'h0, 32'h0, 1'b1, memword(32'hFFFF_FFFC)}) begin
      errors++; $display("FAIL wrap_fetch: got addr=%h pc4=%h v=%b instr=%h expected addr=0 pc4=0 v=1 instr=%h",
                         ImemAddr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instr, memword(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h pc4=%h expected all zero",
                         ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    tick();
    checks++;
    if ({ImemReq, ImemAddr, IF_ID_Valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL ready_in_idle: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", ImemReq, ImemAddr, IF_ID_Valid);
    end
  endtask

  task automatic test_random();
    bit st, rdy, br, j, fl;
    int r;
    for (int n = 0; n < 500; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 7);
      br  = (r < 2);
      j   = (r == 2) || (r == 3 && br);
      fl  = (br | j) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      drive(st, rdy, br, j, fl, $urandom, $urandom);
      tick();
      checks++;
      if ({ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !==
          {(!m_idle && m_skid.size() == 0), m_pc, m_valid, m_instr, m_pc4}) begin
        errors++; $display("FAIL random n=%0d: got req=%b addr=%h v=%b instr=%h pc4=%h, expected addr=%h v=%b instr=%h pc4=%h",
                           n, ImemReq, ImemAddr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, m_pc, m_valid, m_instr, m_pc4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall_skid();
    test_not_ready_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
